uart_ctrl: RTL

Register-mapped host controller for `uart_core`. It owns the UART configuration (divider, enables, stop bits) and buffers traffic in both directions with a TX FIFO and an RX FIFO. It streams TX bytes into the core's valid/ready port and captures RX bytes from the core's one-cycle `rx_valid` pulse. It sits between a simple single-cycle register bus (CPU or bridge) and `uart_core`, and raises a level interrupt.

---
 rtl/uart_ctrl_if.sv | 20 ++
 rtl/uart_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl_if.sv
// Register bus between a host (CPU or bridge) and uart_ctrl.
// Single-cycle strobes; read data comes back one cycle later with sw_rvalid.
interface uart_ctrl_if;
  logic        sw_read;
  logic        sw_write;
  logic [4:0]  sw_addr;
  logic [31:0] sw_wdata;
  logic [31:0] sw_rdata;
  logic        sw_rvalid;

  modport master (
    output sw_read, sw_write, sw_addr, sw_wdata,
    input  sw_rdata, sw_rvalid
  );

  modport slave (
    input  sw_read, sw_write, sw_addr, sw_wdata,
    output sw_rdata, sw_rvalid
  );
endinterface

// File: rtl/uart_ctrl.sv
// Register-mapped host controller for uart_core: configuration registers,
// TX/RX byte FIFOs, sticky error flags and a registered level interrupt.

module uart_ctrl_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wptr_q, wptr_d;
  logic [AW-1:0]           rptr_q, rptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    push_ok, pop_ok;

  // Full/empty come from the registered count, so a push into a full
  // FIFO is refused even when a pop lands in the same cycle.
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rptr_q];
  assign count   = cnt_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop_ok) rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module uart_ctrl #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RST    = 16'd434
) (
  input  logic        clk,
  input  logic        rst_b,
  uart_ctrl_if.slave  bus,
  output logic        irq,
  output logic [15:0] cfg_div,
  output logic        cfg_txen,
  output logic        cfg_rxen,
  output logic        cfg_nstop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_DIV    = 3'd1;
  localparam logic [2:0] A_TXDATA = 3'd2;
  localparam logic [2:0] A_RXDATA = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_IE     = 3'd5;

  logic        txen_q, txen_d, rxen_q, rxen_d, nstop_q, nstop_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  ie_q, ie_d;
  logic        ovr_q, ovr_d, ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        irq_q, irq_d;

  logic [2:0]    addr;
  logic          wr_en, rd_en;
  logic          tx_push, tx_pop, tx_flush;
  logic          rx_pop, rx_flush;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  assign addr  = bus.sw_addr[4:2];
  assign wr_en = bus.sw_write;
  // A write wins over a same-cycle read; that read gets no response.
  assign rd_en = bus.sw_read & ~bus.sw_write;

  assign tx_push  = wr_en & (addr == A_TXDATA);
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_flush = wr_en & (addr == A_CTRL) & bus.sw_wdata[3];
  assign rx_pop   = rd_en & (addr == A_RXDATA);
  assign rx_flush = wr_en & (addr == A_CTRL) & bus.sw_wdata[4];

  assign unused_bits = ^{bus.sw_addr[1:0], bus.sw_wdata[31:16]};

  uart_ctrl_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_txf (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .wdata (bus.sw_wdata[7:0]),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

  uart_ctrl_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rxf (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (rx_valid),
    .pop   (rx_pop),
    .flush (rx_flush),
    .wdata (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );

  assign tx_valid      = txen_q & ~tx_empty;
  assign tx_data       = tx_head;
  assign cfg_div       = div_q;
  assign cfg_txen      = txen_q;
  assign cfg_rxen      = rxen_q;
  assign cfg_nstop     = nstop_q;
  assign bus.sw_rdata  = rdata_q;
  assign bus.sw_rvalid = rvalid_q;
  assign irq           = irq_q;

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL:   rd_mux = {29'd0, nstop_q, rxen_q, txen_q};
      A_DIV:    rd_mux = {16'd0, div_q};
      // Empty reads return 0 rather than the stale head byte.
      A_RXDATA: if (!rx_empty) rd_mux = {1'b1, 23'd0, rx_head};
      A_STATUS: rd_mux = {16'd0, 4'(rx_cnt), 4'(tx_cnt), 2'd0,
                          ovf_q, ovr_q, rx_empty, rx_full, tx_empty, tx_full};
      A_IE:     rd_mux = {29'd0, ie_q};
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    txen_d  = txen_q;
    rxen_d  = rxen_q;
    nstop_d = nstop_q;
    div_d   = div_q;
    ie_d    = ie_q;
    ovr_d   = ovr_q;
    ovf_d   = ovf_q;
    if (wr_en) begin
      case (addr)
        A_CTRL:   {nstop_d, rxen_d, txen_d} = bus.sw_wdata[2:0];
        A_DIV:    div_d = bus.sw_wdata[15:0];
        A_STATUS: begin
          if (bus.sw_wdata[4]) ovr_d = 1'b0;
          if (bus.sw_wdata[5]) ovf_d = 1'b0;
        end
        A_IE:     ie_d = bus.sw_wdata[2:0];
        default:  ;
      endcase
    end
    // Set events are applied after W1C so a coincident set wins.
    if (rx_valid & rx_full) ovr_d = 1'b1;
    if (tx_push & tx_full)  ovf_d = 1'b1;
    rdata_d  = rd_en ? rd_mux : rdata_q;
    rvalid_d = rd_en;
    irq_d    = (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty) |
               (ie_q[2] & (ovr_q | ovf_q));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      txen_q   <= 1'b0;
      rxen_q   <= 1'b0;
      nstop_q  <= 1'b0;
      div_q    <= DIV_RST;
      ie_q     <= '0;
      ovr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      txen_q   <= txen_d;
      rxen_q   <= rxen_d;
      nstop_q  <= nstop_d;
      div_q    <= div_d;
      ie_q     <= ie_d;
      ovr_q    <= ovr_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end
endmodule
